// File: rtl/fir_pkg.sv
// Shared constants and elaboration-time helpers for the programmable FIR filter.
package fir_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >>> 1) begin
            r++;
        end
        return r;
    endfunction

    // Wide enough that summing NTAPS full-scale products can never wrap.
    function automatic int acc_width(input int din_w, input int coef_w, input int ntaps);
        return din_w + coef_w + clog2(ntaps);
    endfunction

    localparam int DEF_TAPS = 13;
    localparam int DEF_COEF13 [DEF_TAPS] = '{-1, 2, 2, -9, -3, 38, 67, 38, -3, -9, 2, 2, -1};

endpackage

// File: rtl/fir_tap.sv
// One transposed-form tap: registers coef*x plus the partial sum from the tap after it.
module fir_tap
    import fir_pkg::*;
#(
    parameter int DIN_W  = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en_i,
    input  logic                     flush_i,
    input  logic signed [DIN_W-1:0]  x_i,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic signed [ACC_W-1:0]  sum_i,
    output logic signed [ACC_W-1:0]  sum_o
);

    localparam int PW = DIN_W + COEF_W;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] sum_q;

    assign prod  = x_i * coef_i;
    assign sum_d = {{(ACC_W-PW){prod[PW-1]}}, prod} + sum_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (flush_i) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/fir_prog.sv
// Programmable transposed-form FIR with shadow/active coefficient banks,
// half-up rounding, output saturation and a sticky saturation flag.
module fir_prog
    import fir_pkg::*;
#(
    parameter int NTAPS  = 13,
    parameter int DIN_W  = 8,
    parameter int COEF_W = 8,
    parameter int DOUT_W = 16,
    parameter int SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [DIN_W-1:0]   din,
    input  logic                      din_valid,
    input  logic                      flush,
    input  logic                      coef_wr,
    input  logic [clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    input  logic                      coef_commit,
    output logic signed [DOUT_W-1:0]  dout,
    output logic                      dout_valid,
    output logic                      sat_flag,
    input  logic                      sat_clr
);

    localparam int ACC_W = acc_width(DIN_W, COEF_W, NTAPS);
    localparam int PW    = DIN_W + COEF_W;
    // One guard bit above the accumulator absorbs the rounding increment.
    localparam int RW    = (ACC_W + 1 > DOUT_W + 1) ? ACC_W + 1 : DOUT_W + 1;
    localparam int SH1   = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [RW-1:0] ONE  = {{(RW-1){1'b0}}, 1'b1};
    localparam logic signed [RW-1:0] RND  = (SHIFT > 0) ? (ONE << SH1) : '0;
    localparam logic signed [RW-1:0] MAXV = {{(RW-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

    function automatic logic signed [COEF_W-1:0] def_coef(input int k);
        if (NTAPS == DEF_TAPS) return COEF_W'(DEF_COEF13[k]);
        return (k == 0) ? COEF_W'(1) : '0;
    endfunction

    function automatic logic signed [RW-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [RW-1:0] t;
        t = {{(RW-ACC_W){a[ACC_W-1]}}, a};
        t = t + RND;
        return t >>> SHIFT;
    endfunction

    function automatic logic signed [DOUT_W-1:0] saturate(input logic signed [RW-1:0] v);
        if (v > MAXV) return MAXV[DOUT_W-1:0];
        if (v < MINV) return MINV[DOUT_W-1:0];
        return v[DOUT_W-1:0];
    endfunction

    function automatic logic is_sat(input logic signed [RW-1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction

    logic signed [COEF_W-1:0] shadow_q [NTAPS];
    logic signed [COEF_W-1:0] shadow_d [NTAPS];
    logic signed [COEF_W-1:0] active_q [NTAPS];

    // A write in the commit cycle must land in the copy, so commit takes shadow_d.
    always_comb begin
        shadow_d = shadow_q;
        if (coef_wr && (int'(coef_addr) < NTAPS)) begin
            shadow_d[coef_addr] = coef_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow_q[k] <= def_coef(k);
                active_q[k] <= def_coef(k);
            end
        end else begin
            shadow_q <= shadow_d;
            if (coef_commit) begin
                active_q <= shadow_d;
            end
        end
    end

    logic signed [ACC_W-1:0] sum [1:NTAPS];

    assign sum[NTAPS] = '0;

    for (genvar k = 1; k < NTAPS; k++) begin : g_tap
        fir_tap #(
            .DIN_W  (DIN_W),
            .COEF_W (COEF_W),
            .ACC_W  (ACC_W)
        ) u_tap (
            .clk     (clk),
            .reset   (reset),
            .en_i    (din_valid),
            .flush_i (flush),
            .x_i     (din),
            .coef_i  (active_q[k]),
            .sum_i   (sum[k+1]),
            .sum_o   (sum[k])
        );
    end

    logic signed [PW-1:0]     prod0;
    logic signed [ACC_W-1:0]  acc;
    logic signed [RW-1:0]     rs;
    logic signed [DOUT_W-1:0] dout_d, dout_q;
    logic                     vld_d, vld_q;
    logic                     sat_d, sat_q;

    assign prod0 = din * active_q[0];
    assign acc   = {{(ACC_W-PW){prod0[PW-1]}}, prod0} + sum[1];
    assign rs    = round_shift(acc);

    always_comb begin
        dout_d = dout_q;
        vld_d  = 1'b0;
        sat_d  = sat_q;
        if (flush) begin
            dout_d = '0;
        end else if (din_valid) begin
            dout_d = saturate(rs);
            vld_d  = 1'b1;
        end
        // Setting beats clearing when both happen in one cycle.
        if (din_valid && !flush && is_sat(rs)) begin
            sat_d = 1'b1;
        end else if (sat_clr) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vld_q  <= vld_d;
            sat_q  <= sat_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_fir_prog.sv
// Directed self-checking bench for fir_prog with default parameters.
module tb_fir_prog;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [7:0] din;
    logic              din_valid;
    logic              flush;
    logic              coef_wr;
    logic [3:0]        coef_addr;
    logic signed [7:0] coef_data;
    logic              coef_commit;
    logic signed [15:0] dout;
    logic              dout_valid;
    logic              sat_flag;
    logic              sat_clr;

    int checks   = 0;
    int failures = 0;

    localparam int IMP [14]  = '{-1, 2, 2, -9, -3, 38, 67, 38, -3, -9, 2, 2, -1, 0};
    localparam int STEP [13] = '{-127, 127, 381, -762, -1143, 3683, 12192, 17018,
                                 16637, 15494, 15748, 16002, 15875};

    typedef struct {
        logic v;
        logic f;
        int   d;
        logic ev;
        int   ed;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    fir_prog #(
        .NTAPS  (13),
        .DIN_W  (8),
        .COEF_W (8),
        .DOUT_W (16),
        .SHIFT  (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .flush       (flush),
        .coef_wr     (coef_wr),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .coef_commit (coef_commit),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .sat_flag    (sat_flag),
        .sat_clr     (sat_clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input int d);
        din_valid = 1'b1;
        din       = 8'(d);
        cyc();
        din_valid = 1'b0;
        din       = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    task automatic wr(input int a, input int d, input logic c);
        coef_wr     = 1'b1;
        coef_addr   = 4'(a);
        coef_data   = 8'(d);
        coef_commit = c;
        cyc();
        coef_wr     = 1'b0;
        coef_commit = 1'b0;
    endtask

    task automatic impulse(input string name);
        for (int i = 0; i < 14; i++) begin
            samp((i == 0) ? 1 : 0);
            chk({name, "_vld"}, int'(dout_valid), 1);
            chk({name, "_dout"}, int'(dout), IMP[i]);
        end
        chk({name, "_sat"}, int'(sat_flag), 0);
    endtask

    function automatic void add(input logic v, input logic f, input int d, input logic ev, input int ed);
        vec_t t;
        t.v = v; t.f = f; t.d = d; t.ev = ev; t.ed = ed;
        tbl.push_back(t);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, last, guard;
        logic v;

        reset = 1'b1; din = '0; din_valid = 1'b0; flush = 1'b0; coef_wr = 1'b0;
        coef_addr = '0; coef_data = '0; coef_commit = 1'b0; sat_clr = 1'b0;

        // Impulse, hold, step, hold with changing din, flush beating a sample.
        for (int i = 0; i < 14; i++) add(1'b1, 1'b0, (i == 0) ? 1 : 0, 1'b1, IMP[i]);
        add(1'b0, 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 20; i++) add(1'b1, 1'b0, 127, 1'b1, (i < 13) ? STEP[i] : 15875);
        add(1'b0, 1'b0, 55, 1'b0, 15875);
        add(1'b1, 1'b1, 100, 1'b0, 0);
        add(1'b1, 1'b0, 1, 1'b1, -1);
        add(1'b1, 1'b0, 0, 1'b1, 2);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", int'(dout), 0);
        chk("rst_vld", int'(dout_valid), 0);
        chk("rst_sat", int'(sat_flag), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            din_valid = tbl[i].v;
            flush     = tbl[i].f;
            din       = 8'(tbl[i].d);
            cyc();
            chk($sformatf("tbl%0d_vld", i), int'(dout_valid), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_dout", i), int'(dout), tbl[i].ed);
        end
        din_valid = 1'b0; flush = 1'b0; din = '0;
        chk("tbl_sat", int'(sat_flag), 0);

        // Impulse with irregular din_valid; dout must hold between strobes.
        do_flush();
        idx = 0; last = 0; guard = 0;
        while (idx < 14 && guard < 300) begin
            v = (guard == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            din_valid = v;
            din       = (idx == 0) ? 8'sd1 : 8'sd0;
            cyc();
            if (v) begin
                chk($sformatf("rnd%0d_vld", idx), int'(dout_valid), 1);
                chk($sformatf("rnd%0d_dout", idx), int'(dout), IMP[idx]);
                last = IMP[idx];
                idx++;
            end else begin
                chk("rnd_hold_vld", int'(dout_valid), 0);
                chk("rnd_hold_dout", int'(dout), last);
            end
            guard++;
        end
        din_valid = 1'b0; din = '0;
        chk("rnd_done", idx, 14);

        // Bank A: h0=3, others 0; h0 written in the commit cycle itself.
        do_flush();
        for (int k = 1; k < 13; k++) wr(k, 0, 1'b0);
        wr(13, 77, 1'b0);
        wr(0, 3, 1'b1);
        samp(5);
        chk("bankA_dout", int'(dout), 15);

        // Commit h0=2 together with a sample: that sample still sees bank A.
        coef_wr = 1'b1; coef_addr = 4'd0; coef_data = 8'sd2; coef_commit = 1'b1;
        din_valid = 1'b1; din = 8'sd5;
        cyc();
        coef_wr = 1'b0; coef_commit = 1'b0; din_valid = 1'b0; din = '0;
        chk("commit_old", int'(dout), 15);
        samp(5);
        chk("commit_new", int'(dout), 10);
        wr(0, 7, 1'b0);
        samp(5);
        chk("shadow_only", int'(dout), 10);

        // All coefficients 127, negative full scale input.
        for (int k = 0; k < 13; k++) wr(k, 127, (k == 12) ? 1'b1 : 1'b0);
        do_flush();
        for (int k = 1; k <= 13; k++) begin
            samp(-128);
            chk($sformatf("neg%0d_dout", k), int'(dout), (k < 3) ? -16256 * k : -32768);
            if (k == 2) chk("neg2_sat", int'(sat_flag), 0);
        end
        chk("neg_sat", int'(sat_flag), 1);
        sat_clr = 1'b1;
        samp(-128);
        sat_clr = 1'b0;
        chk("setwins_sat", int'(sat_flag), 1);
        do_flush();
        chk("flush_sat_kept", int'(sat_flag), 1);
        chk("flush_dout", int'(dout), 0);
        chk("flush_vld", int'(dout_valid), 0);
        sat_clr = 1'b1;
        cyc();
        sat_clr = 1'b0;
        chk("satclr", int'(sat_flag), 0);
        samp(127);
        chk("pos1", int'(dout), 16129);
        samp(127);
        chk("pos2", int'(dout), 32258);
        chk("pos2_sat", int'(sat_flag), 0);
        samp(127);
        chk("pos3", int'(dout), 32767);
        chk("pos3_sat", int'(sat_flag), 1);
        samp(127);

        // Asynchronous reset mid-stream restores defaults and empties the taps.
        #1;
        reset = 1'b1;
        #1;
        chk("arst_dout", int'(dout), 0);
        chk("arst_vld", int'(dout_valid), 0);
        chk("arst_sat", int'(sat_flag), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        impulse("post_rst");

        // Flush mid-impulse, then a fresh impulse.
        for (int i = 0; i < 3; i++) begin
            samp((i == 0) ? 1 : 0);
            chk($sformatf("part%0d", i), int'(dout), IMP[i]);
        end
        do_flush();
        chk("mid_flush_dout", int'(dout), 0);
        chk("mid_flush_vld", int'(dout_valid), 0);
        impulse("post_flush");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_prog.md
FIR_PROG -- requirements
Module: fir_prog

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NTAPS  13  number of taps, 2..64
  DIN_W  8  signed sample width
  COEF_W  8  signed coefficient width
  DOUT_W  16  signed output width
  SHIFT  0  arithmetic right shift applied before output, 0..ACC_W-1
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-high
  din  in  DIN_W  signed sample
  din_valid  in  1  sample strobe
  flush  in  1  synchronous clear of delay line
  coef_wr  in  1  shadow coefficient write strobe
  coef_addr  in  clog2(NTAPS)  tap index
  coef_data  in  COEF_W  signed coefficient
  coef_commit  in  1  copy shadow bank to active bank
  dout  out  DOUT_W  signed filtered sample
  dout_valid  out  1  dout updated this cycle
  sat_flag  out  1  sticky saturation indicator
  sat_clr  in  1  clears sat_flag

Function
REQ-003 Filter SHALL use transposed form: y[n] = sum over k=0..NTAPS-1 of h[k]*x[n-k], using active coefficients.
REQ-004 Delay line SHALL advance only on cycles with din_valid=1; with din_valid=0, all tap registers and dout SHALL hold.
REQ-005 Latency SHALL be 1: the edge sampling din_valid=1 registers y[n] into dout and sets dout_valid=1 for the following cycle only.
REQ-006 Internal accumulator width ACC_W SHALL be DIN_W+COEF_W+clog2(NTAPS); no intermediate overflow permitted.
REQ-007 Output SHALL be the accumulator arithmetically shifted right by SHIFT, rounded half-up (add 2^(SHIFT-1) before shifting when SHIFT>0), then saturated to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
REQ-008 Any saturation on an accepted sample SHALL set sat_flag; it stays set until sat_clr=1; set wins over sat_clr in the same cycle.
REQ-009 coef_wr=1 SHALL write coef_data to shadow[coef_addr]; coef_addr >= NTAPS SHALL be ignored.
REQ-010 coef_commit=1 SHALL copy the full shadow bank to the active bank on that edge; a coef_wr in the same cycle SHALL be included in the copy.
REQ-011 A sample accepted in the same cycle as coef_commit SHALL use the old active bank; the new bank applies from the next accepted sample; tap contents are not cleared.
REQ-012 flush=1 SHALL zero all tap registers and dout and force dout_valid=0; coefficients and sat_flag are unaffected.
REQ-013 flush and din_valid in the same cycle: flush SHALL win and the sample is discarded.

Reset
REQ-014 reset SHALL asynchronously clear tap registers, dout=0, dout_valid=0, sat_flag=0.
REQ-015 reset SHALL load both shadow and active banks with default coefficients -1,2,2,-9,-3,38,67,38,-3,-9,2,2,-1 for NTAPS=13; other NTAPS SHALL reset to h[0]=1, rest 0.
REQ-016 reset asserted mid-stream SHALL discard all in-flight partial sums; the first sample after deassertion sees an all-zero history.

Structure
REQ-017 Package fir_pkg SHALL hold the clog2 function, the ACC_W computation, and the 13-tap default coefficient constant.
REQ-018 One sub-module fir_tap (multiply, add, register, with hold and flush) SHALL be generated NTAPS-1 times; output rounding and saturation live in fir_prog.

Verification
REQ-019 Impulse with defaults, SHIFT=0: din=1 once, then zeros -> dout sequence -1,2,2,-9,-3,38,67,38,-3,-9,2,2,-1, then 0; sat_flag=0.
REQ-020 Step with din=127 held for 20 samples -> dout settles at 15875 after the 13th sample.
REQ-021 Load all coefficients=127, commit, din=-128 for 13 samples -> dout=-32768 and sat_flag=1; sat_clr with no further saturation -> 0.
REQ-022 Impulse with din_valid toggled randomly -> the same 13-value sequence on dout_valid cycles, with dout held between them.
REQ-023 Commit of h[0]=2 (rest 0) in the same cycle as sample din=5 -> that output uses the old bank; next din=5 -> dout=10.
REQ-024 reset and then flush asserted mid-impulse -> dout=0, dout_valid=0; next impulse reproduces REQ-019 from its first value.
